// File: rtl/seq_pkg.sv
// Shared constants for the 1101 serial link: FSM states, sync marker and stuff trigger.
// Also imported by the detector's bench, so the marker definition lives in one place.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MARK  = 3'd1,
        S_DATA  = 3'd2,
        S_STUFF = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int                  MARKER_W   = 4;
    localparam logic [MARKER_W-1:0] MARKER     = 4'b1101;
    localparam logic [2:0]          STUFF_TRIG = 3'b110;

endpackage

// File: rtl/seq_tx_stuff_ctl.sv
// Zero-stuff decision: tracks the last three emitted frame bits and requests a stuffed 0
// when the bit on the line completes 110. Request is combinational from registered state.
module seq_tx_stuff_ctl
    import seq_pkg::*;
(
    input  logic clock_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic bit_i,
    input  logic vld_i,
    output logic stuff_req_o
);
    logic [2:0] hist_q;
    logic [2:0] hist_d;

    // hist_d is the history including the bit currently on the line.
    assign hist_d = {hist_q[1:0], bit_i};

    always_ff @(posedge clock_i) begin
        if (rst_i || clr_i) begin
            hist_q <= 3'b000;
        end else if (vld_i) begin
            hist_q <= hist_d;
        end
    end

    assign stuff_req_o = vld_i && (hist_d == STUFF_TRIG);

endmodule

// File: rtl/seq_1101_tx.sv
// Frames a DATA_W word as marker 1101 + payload MSB-first, one bit per clock, then IDLE_GAP idle cycles.
// First marker bit the cycle after start is accepted; start is honoured only while ready (no queuing).
// Build with SEQ_TX_STUFF_EN to insert stuffed zeros so the payload never re-forms the marker.
module seq_1101_tx
    import seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int IDLE_GAP = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              d_out,
    output logic              d_valid,
    output logic              d_stuff,
    output logic              done
);
    localparam int         CNT_W  = $clog2(DATA_W + IDLE_GAP + MARKER_W + 1);
    localparam logic [1:0] MK_TOP = 2'(MARKER_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  pay_cnt;
    logic              d_out_q;
    logic              d_valid_q;
    logic              d_stuff_q;
    logic              done_q;
    logic              stuff_req;

`ifdef SEQ_TX_STUFF_EN
    seq_tx_stuff_ctl u_stuff_ctl (
        .clock_i     (clock),
        .rst_i       (rst),
        .clr_i       (ready && start),
        .bit_i       (d_out_q),
        .vld_i       (d_valid_q),
        .stuff_req_o (stuff_req)
    );
`else
    assign stuff_req = 1'b0;
`endif

    // cnt_q counts marker bits while in MARK and payload bits afterwards.
    assign pay_cnt = (state_q == S_MARK) ? '0 : cnt_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_stuff_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_stuff_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_MARK;
                        shreg_q   <= data_in;
                        cnt_q     <= CNT_W'(1);
                        d_out_q   <= MARKER[MK_TOP];
                        d_valid_q <= 1'b1;
                    end
                end
                S_MARK, S_DATA, S_STUFF: begin
                    if (state_q == S_MARK && cnt_q < CNT_W'(MARKER_W)) begin
                        cnt_q     <= cnt_q + 1'b1;
                        d_out_q   <= MARKER[MK_TOP - cnt_q[1:0]];
                        d_valid_q <= 1'b1;
                    end else if (state_q == S_DATA && cnt_q == CNT_W'(DATA_W)) begin
                        done_q <= 1'b1;
                        if (IDLE_GAP == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GAP;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else if (stuff_req) begin
                        // Stuffed 0 occupies a slot without consuming a payload bit.
                        state_q   <= S_STUFF;
                        cnt_q     <= pay_cnt;
                        d_valid_q <= 1'b1;
                        d_stuff_q <= 1'b1;
                    end else begin
                        state_q   <= S_DATA;
                        cnt_q     <= pay_cnt + 1'b1;
                        d_out_q   <= shreg_q[DATA_W-1];
                        d_valid_q <= 1'b1;
                        shreg_q   <= shreg_q << 1;
                    end
                end
                S_GAP: begin
                    if (cnt_q >= CNT_W'(IDLE_GAP)) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign d_stuff = d_stuff_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_1101_tx.sv
// Self-checking bench for seq_1101_tx: frames checked bit-by-bit against a queue-built frame model.
// Build with SEQ_TX_STUFF_EN defined to check the stuffing variant.
module tb_seq_1101_tx;
    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef SEQ_TX_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          ready, d_out, d_valid, d_stuff, done;

    int checks   = 0;
    int failures = 0;

    bit exp_bits[$];
    bit exp_stuff[$];
    int exp_det;

    seq_1101_tx #(.DATA_W(DW), .IDLE_GAP(GAP)) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .ready   (ready),
        .d_out   (d_out),
        .d_valid (d_valid),
        .d_stuff (d_stuff),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Frame model: marker, then payload MSB-first with a 0 inserted whenever the last three bits are 110.
    task automatic build_model(input logic [DW-1:0] d);
        logic [3:0] mk;
        int n;
        mk = 4'b1101;
        exp_bits.delete();
        exp_stuff.delete();
        for (int i = 3; i >= 0; i--) begin
            exp_bits.push_back(mk[i]);
            exp_stuff.push_back(1'b0);
        end
        for (int i = DW - 1; i >= 0; i--) begin
            n = exp_bits.size();
            if (STUFF_ON && exp_bits[n-3] && exp_bits[n-2] && !exp_bits[n-1]) begin
                exp_bits.push_back(1'b0);
                exp_stuff.push_back(1'b1);
            end
            exp_bits.push_back(d[i]);
            exp_stuff.push_back(1'b0);
        end
        exp_det = 0;
        for (int i = 0; i + 3 < exp_bits.size(); i++)
            if ({exp_bits[i], exp_bits[i+1], exp_bits[i+2], exp_bits[i+3]} == 4'b1101) exp_det++;
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input bit poke, output int nvalid, output int ndet);
        logic [3:0] win;
        int n;
        build_model(d);
        win = 4'b0000;
        nvalid = 0;
        ndet = 0;
        n = 0;
        while (ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready d=%h ready=%b required 1 within 64 cycles", d, ready);
        end
        start = 1'b1;
        data_in = d;
        step();
        start = 1'b0;
        data_in = DW'($urandom);
        for (int i = 0; i < exp_bits.size(); i++) begin
            checks++;
            if ({d_valid, d_out, d_stuff, ready, done} !== {1'b1, exp_bits[i], exp_stuff[i], 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL frame_bit d=%h idx=%0d valid/out/stuff/ready/done=%b required %b",
                         d, i, {d_valid, d_out, d_stuff, ready, done},
                         {1'b1, exp_bits[i], exp_stuff[i], 1'b0, 1'b0});
            end
            if (d_valid === 1'b1) begin
                nvalid++;
                win = {win[2:0], d_out};
                if (win == 4'b1101) ndet++;
            end
            start = poke && (i == 1 || i == 6);
            data_in = DW'($urandom);
            step();
        end
        start = 1'b0;
        checks++;
        if ({d_valid, d_out, d_stuff, done, ready} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'(GAP == 0)}) begin
            failures++;
            $display("FAIL done_cycle d=%h valid/out/stuff/done/ready=%b required %b",
                     d, {d_valid, d_out, d_stuff, done, ready}, {1'b0, 1'b0, 1'b0, 1'b1, 1'(GAP == 0)});
        end
        for (int g = 1; g <= GAP; g++) begin
            step();
            checks++;
            if ({ready, done, d_valid} !== {1'(g == GAP), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL gap d=%h g=%0d ready/done/valid=%b required %b",
                         d, g, {ready, done, d_valid}, {1'(g == GAP), 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({d_out, d_valid, d_stuff, done, ready} !== 5'b00001) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d out/valid/stuff/done/ready=%b required 00001",
                         i, {d_out, d_valid, d_stuff, done, ready});
            end
            step();
        end
        rst = 1'b1;
        start = 1'b1;
        data_in = 8'hFF;
        step();
        checks++;
        if ({ready, d_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_wins ready/valid=%b required 10", {ready, d_valid});
        end
        rst = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if ({ready, d_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_wins_after ready/valid=%b required 10", {ready, d_valid});
        end
    endtask

    task automatic test_fixed_words();
        logic [DW-1:0] words[4];
        int lens[4];
        int dets[4];
        int nv, nd;
        words = '{8'h00, 8'hA5, 8'h6D, 8'hFF};
        lens  = '{12, STUFF_ON ? 13 : 12, STUFF_ON ? 14 : 12, 12};
        dets  = '{1, STUFF_ON ? 1 : 2, STUFF_ON ? 1 : 3, 1};
        for (int k = 0; k < 4; k++) begin
            run_frame(words[k], 1'b0, nv, nd);
            checks++;
            if (nv !== lens[k]) begin
                failures++;
                $display("FAIL fixed_len d=%h valid_cycles=%0d required %0d", words[k], nv, lens[k]);
            end
            checks++;
            if (nd !== dets[k]) begin
                failures++;
                $display("FAIL fixed_detect d=%h matches=%0d required %0d", words[k], nd, dets[k]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int nv, nd;
        run_frame(8'h3C, 1'b1, nv, nd);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({d_valid, ready} !== 2'b01) begin
                failures++;
                $display("FAIL no_second_frame cyc=%0d valid/ready=%b required 01", i, {d_valid, ready});
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        int nv, nd;
        start = 1'b1;
        data_in = 8'hB7;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({d_valid, d_out, d_stuff, done, ready} !== 5'b00001) begin
            failures++;
            $display("FAIL mid_reset valid/out/stuff/done/ready=%b required 00001",
                     {d_valid, d_out, d_stuff, done, ready});
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({done, d_valid} !== 2'b00) begin
                failures++;
                $display("FAIL aborted_quiet cyc=%0d done/valid=%b required 00", i, {done, d_valid});
            end
        end
        run_frame(8'hB7, 1'b0, nv, nd);
        checks++;
        if (nv !== exp_bits.size()) begin
            failures++;
            $display("FAIL restart_len valid_cycles=%0d required %0d", nv, exp_bits.size());
        end
    endtask

    task automatic test_back_to_back_random();
        logic [DW-1:0] d;
        int nv, nd;
        for (int k = 0; k < 24; k++) begin
            d = DW'($urandom);
            run_frame(d, 1'($urandom_range(0, 1)), nv, nd);
            checks++;
            if (nv !== exp_bits.size() || nd !== exp_det) begin
                failures++;
                $display("FAIL random d=%h valid_cycles=%0d matches=%0d required %0d and %0d",
                         d, nv, nd, exp_bits.size(), exp_det);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_words();
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_1101_tx.md
# seq_1101_tx

Serial frame transmitter that produces the bitstream consumed by the team's 1101 sequence detector. It accepts a parallel word on a start/ready handshake and emits a frame, one bit per clock: the 4-bit sync marker 1101, then the payload MSB-first. An optional zero-stuffing rule guarantees that the payload never recreates the marker. The block sits on the transmit side of the lab serial link, and its `d_out` feeds the detector's `d_in` directly.

## Interface
- `DATA_W`, default 8: payload width in bits (≥1).
- `IDLE_GAP`, default 2: minimum number of idle cycles (`d_out`=0) after each frame before `ready` returns (≥0).
- `clock` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request to send. It is accepted only on a cycle where `ready`=1.
- `data_in` in DATA_W: payload. It is captured on the accepting edge.
- `ready` out 1: high only in IDLE.
- `d_out` out 1: serial bit. It is 0 whenever `d_valid`=0.
- `d_valid` out 1: `d_out` carries a frame bit (marker, payload or stuff).
- `d_stuff` out 1: the current bit is a stuffed 0. Tied to 0 when stuffing is compiled out.
- `done` out 1: one-cycle pulse after the last frame bit.

## Operation
- States:
  - IDLE: `ready`=1. A start in this state captures `data_in` into the shift register, clears the history register and moves to MARK.
  - MARK: 4 cycles, emitting 1,1,0,1 with `d_valid`=1.
  - DATA: DATA_W payload cycles, MSB first.
  - STUFF: 1 cycle, emitting 0, then returns to DATA.
  - GAP: IDLE_GAP cycles. `done` pulses on the first GAP cycle. If IDLE_GAP=0, `done` pulses on the IDLE cycle instead, and a start is legal on that cycle.
- History register: 3 bits, holding the last three emitted frame bits, marker bits included. It shifts on every `d_valid` cycle.
- Stuffing rule (stuffing compiled in):
  - Before each payload bit, if history == 3'b110, emit a stuffed 0 first. The payload bit is not consumed.
  - There is no check after the last payload bit, because the trailing idle zeros are safe.
- Frame length: 4 + DATA_W + S cycles, where S is the number of stuffs (0 ≤ S ≤ DATA_W/2).
- `start` outside IDLE is ignored, with no queuing. `data_in` is don't-care except on the accepting edge.
- All outputs are registered or decoded from registered state, so there is no combinational path from `start` or `data_in`.

## Timing
- Reset values: `d_out`=0, `d_valid`=0, `d_stuff`=0, `done`=0, `ready`=1, state=IDLE, history=0.
- On the edge after reset is sampled high, the block is in IDLE and `ready`=1.
- Start latency:
  - Start is sampled on edge N.
  - The first marker bit appears after edge N, with `ready`=0 from that cycle.
- `done` is high for exactly one cycle, immediately after the last payload bit.
- `ready` returns IDLE_GAP cycles after the `done` cycle. With IDLE_GAP=0 it is high on the `done` cycle itself.
- Reset asserted in any state:
  - On the next edge: IDLE, all outputs at their reset values, `ready`=1.
  - No `done` is issued for an aborted frame.
- Start and reset high on the same edge: reset wins.

## Configuration
- Macro: `SEQ_TX_STUFF_EN`.
- Defined:
  - The STUFF state and the stuff decision are built.
  - The payload can never form 1101 anywhere in the stream after the marker.
- Undefined:
  - The payload is sent raw, S=0 always, and `d_stuff`=0.
  - The history register may be optimized away.
  - False markers are possible.

## Structure
- Shared package `seq_pkg`:
  - State encoding localparams `S_IDLE`, `S_MARK`, `S_DATA`, `S_STUFF`, `S_GAP`.
  - `MARKER` = 4'b1101 and `MARKER_W` = 4, also used by the detector's bench.
  - `STUFF_TRIG` = 3'b110.
- One sub-module is natural: `seq_tx_stuff_ctl`. It holds the history register and produces the stuff request from the emitted bit and `d_valid`. It is instantiated only under `SEQ_TX_STUFF_EN`.

## Test plan
- Reset with `start`=0 → `d_out`=0, `d_valid`=0, `done`=0, `ready`=1 held for 10 cycles.
- DATA_W=8, IDLE_GAP=2, `data_in`=8'h00, both macro builds → stream 1101_00000000 (12 valid cycles), `done` on cycle 13, `ready` high 2 cycles later.
- 8'hA5 with stuffing → 1101_10 0 100101 (13 cycles, `d_stuff` on bit 7). Without stuffing → 110110100101 (12 cycles, contains a false 1101 at bits 3–6). The detector model flags only the stuffed stream as a single match.
- 8'h6D with stuffing → 1101_0110 0 110 0 1 (14 cycles, two stuffs). 8'hFF → 1101_11111111 with no stuffs.
- `start` pulsed during MARK and DATA → ignored, the frame is unchanged and no second frame is sent.
- Reset asserted mid-DATA → next cycle `d_valid`=0, `ready`=1, no `done`. A new start then yields a clean marker and a full frame.
